// File: rtl/mod_reduce_pkg.sv
// Shared constants and FSM encoding for the modular reducer and its request arbiter.
package mod_reduce_pkg;

  localparam logic [22:0] Q              = 23'd8380417;
  localparam int          DATA_WIDTH_DEF = 48;
  localparam int          Q_WIDTH_DEF    = 23;
  localparam int          TIMEOUT_DEF    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mod_reduce_arbiter_if.sv
// Requester and reducer-facing signals of the shared-reducer arbiter.
interface mod_reduce_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 48,
  parameter int Q_WIDTH    = 23,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [Q_WIDTH-1:0]            rsp_data;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic                          rsp_err;
  logic                          red_start;
  logic [DATA_WIDTH-1:0]         red_data_in;
  logic                          red_done;
  logic [Q_WIDTH-1:0]            red_data_out;

  modport slave (
    input  req_valid, req_data, red_done, red_data_out,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, red_start, red_data_in
  );

  modport master (
    output req_valid, req_data, red_done, red_data_out,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, red_start, red_data_in
  );
endinterface

// File: rtl/rr_arbiter.sv
// Stateless round-robin grant: first set request after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] gnt_idx,
  output logic                any
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/mod_reduce_arbiter.sv
// Shares one start/done modular reducer among NUM_REQ requesters, one operation at a time,
// with a watchdog on the reducer and responses tagged by requester index.
module mod_reduce_arbiter
  import mod_reduce_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int Q_WIDTH    = Q_WIDTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int ID_WIDTH   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mod_reduce_arbiter_if.slave  bus,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   gid_q, gid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  red_start_q, red_start_d;
  logic [DATA_WIDTH-1:0] red_data_q, red_data_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [Q_WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  tmo_q, tmo_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic                  gnt_any;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    cnt_d       = cnt_q;
    red_start_d = 1'b0;
    red_data_d  = red_data_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    tmo_d       = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          red_data_d  = bus.req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
          gid_d       = gnt_idx;
          ptr_d       = gnt_idx;
          red_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the final watchdog cycle still delivers its result.
        if (bus.red_done) begin
          rsp_data_d  = bus.red_data_out;
          rsp_err_d   = 1'b0;
          rsp_id_d    = gid_q;
          rsp_valid_d = NUM_REQ'(1) << gid_q;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_id_d    = gid_q;
          rsp_valid_d = NUM_REQ'(1) << gid_q;
          tmo_d       = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        rsp_err_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= ID_WIDTH'(NUM_REQ - 1);
      gid_q       <= '0;
      cnt_q       <= '0;
      red_start_q <= 1'b0;
      red_data_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      cnt_q       <= cnt_d;
      red_start_q <= red_start_d;
      red_data_q  <= red_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.req_ready   = (state_q == ST_IDLE) ? gnt : '0;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.red_start   = red_start_q;
  assign bus.red_data_in = red_data_q;
  assign busy            = (state_q != ST_IDLE);
  assign timeout_err     = tmo_q;

endmodule

// File: tb/tb_mod_reduce_arbiter.sv
// Directed bench for mod_reduce_arbiter with a behavioural reducer (fixed latency, optional hang).
module tb_mod_reduce_arbiter;
  import mod_reduce_pkg::*;

  localparam int RLAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, timeout_err;

  logic [3:0]  rv;
  logic [47:0] rd [4];
  logic        spur, hang;
  logic        mdl_done;
  logic [22:0] mdl_out;
  logic [47:0] mdl_cap;
  int          mdl_cnt;

  int checks = 0;
  int errors = 0;

  mod_reduce_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(48), .Q_WIDTH(23), .ID_WIDTH(2)) bus ();

  mod_reduce_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(48), .Q_WIDTH(23), .TIMEOUT(32), .ID_WIDTH(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  assign bus.req_valid    = rv;
  assign bus.req_data     = {rd[3], rd[2], rd[1], rd[0]};
  assign bus.red_done     = mdl_done | spur;
  assign bus.red_data_out = mdl_out;

  // Reducer model: done one cycle after its countdown expires; result = data mod Q.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_done <= 1'b0;
      mdl_out  <= '0;
      mdl_cap  <= '0;
      mdl_cnt  <= 0;
    end else begin
      mdl_done <= 1'b0;
      if (bus.red_start && !hang) begin
        mdl_cap <= bus.red_data_in;
        mdl_cnt <= RLAT;
      end else if (mdl_cnt == 1) begin
        mdl_done <= 1'b1;
        mdl_out  <= 23'(mdl_cap % {25'd0, Q});
        mdl_cnt  <= 0;
      end else if (mdl_cnt != 0) begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rv    = '0;
    spur  = 1'b0;
    hang  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Called at a sample point in IDLE with req_valid already driven.
  task automatic do_op(input int g, input logic [47:0] din, input logic [22:0] dout,
                       input logic err, input logic drop, input int lat, input logic spur_resp);
    logic [3:0] oh;
    int n;
    oh = 4'b0001 << g;
    #1;
    chk("grant", {60'd0, bus.req_ready}, {60'd0, oh});
    tick();
    if (drop) rv[g] = 1'b0;
    chk("issue_start", {63'd0, bus.red_start}, 64'd1);
    chk("issue_data", {16'd0, bus.red_data_in}, {16'd0, din});
    chk("issue_busy_noready", {59'd0, busy, bus.req_ready}, {59'd0, 1'b1, 4'd0});
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) chk("wait_start_low", {63'd0, bus.red_start}, 64'd0);
    end while (bus.rsp_valid == 4'd0 && n < 60);
    chk("resp_latency", 64'(n), 64'(lat));
    chk("rsp_valid", {60'd0, bus.rsp_valid}, {60'd0, oh});
    chk("rsp_id", {62'd0, bus.rsp_id}, 64'(g));
    chk("rsp_data", {41'd0, bus.rsp_data}, {41'd0, dout});
    chk("rsp_err", {63'd0, bus.rsp_err}, {63'd0, err});
    if (spur_resp) spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("post_rsp_idle", {59'd0, busy, bus.rsp_valid}, 64'd0);
    chk("rsp_data_hold", {41'd0, bus.rsp_data}, {41'd0, dout});
  endtask

  initial begin
    rst_n = 1'b0;
    rv    = '0;
    spur  = 1'b0;
    hang  = 1'b0;
    for (int i = 0; i < 4; i++) rd[i] = '0;
    #1;
    chk("reset_req_rsp", {56'd0, bus.req_ready, bus.rsp_valid}, 64'd0);
    chk("reset_red", {15'd0, bus.red_start, bus.red_data_in}, 64'd0);
    chk("reset_status", {62'd0, busy, timeout_err}, 64'd0);
    chk("reset_rsp_fields", {38'd0, bus.rsp_data, bus.rsp_id, bus.rsp_err}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single request, 8380418 mod Q = 1
    rd[0] = 48'd8380418;
    rv    = 4'b0001;
    do_op(0, 48'd8380418, 23'd1, 1'b0, 1'b1, 5, 1'b0);

    // Four simultaneous requests served 0..3 from a fresh pointer
    do_reset();
    rd[0] = 48'd10; rd[1] = 48'd20; rd[2] = 48'd30; rd[3] = 48'd16760834;
    rv    = 4'b1111;
    do_op(0, 48'd10, 23'd10, 1'b0, 1'b1, 5, 1'b0);
    do_op(1, 48'd20, 23'd20, 1'b0, 1'b1, 5, 1'b0);
    do_op(2, 48'd30, 23'd30, 1'b0, 1'b1, 5, 1'b0);
    do_op(3, 48'd16760834, 23'd0, 1'b0, 1'b1, 5, 1'b0);

    // Fairness between two continuously valid requesters
    rd[0] = 48'd5; rd[2] = 48'd7;
    rv    = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) do_op(0, 48'd5, 23'd5, 1'b0, 1'b0, 5, 1'b0);
      else            do_op(2, 48'd7, 23'd7, 1'b0, 1'b0, 5, 1'b0);
    end
    rv = '0;
    chk("fair_timeout_clear", {63'd0, timeout_err}, 64'd0);

    // Watchdog: 1 ISSUE->WAIT edge plus 32 WAIT cycles
    hang  = 1'b1;
    rd[1] = 48'd100;
    rv    = 4'b0010;
    do_op(1, 48'd100, 23'd0, 1'b1, 1'b1, 33, 1'b0);
    chk("timeout_sticky", {63'd0, timeout_err}, 64'd1);
    hang  = 1'b0;
    rd[3] = 48'd8380422;
    rv    = 4'b1000;
    do_op(3, 48'd8380422, 23'd5, 1'b0, 1'b1, 5, 1'b0);
    chk("timeout_still_sticky", {63'd0, timeout_err}, 64'd1);

    // Reset in the middle of WAIT
    rd[0] = 48'd50;
    rv    = 4'b0001;
    #1;
    chk("mid_grant", {60'd0, bus.req_ready}, 64'd1);
    tick();
    rv = '0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outs", {15'd0, bus.red_start, bus.red_data_in}, 64'd0);
    chk("mid_reset_rsp", {34'd0, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err}, 64'd0);
    chk("mid_reset_status", {62'd0, busy, timeout_err}, 64'd0);
    tick();
    tick();
    chk("mid_reset_norsp", {60'd0, bus.rsp_valid}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_release_idle", {63'd0, busy}, 64'd0);
    rd[0] = 48'd25141253;
    rd[1] = 48'd9;
    rv    = 4'b0011;
    do_op(0, 48'd25141253, 23'd2, 1'b0, 1'b1, 5, 1'b0);
    do_op(1, 48'd9, 23'd9, 1'b0, 1'b1, 5, 1'b0);

    // Spurious done in IDLE, then in RESP
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("spur_idle", {58'd0, busy, bus.red_start, bus.rsp_valid}, 64'd0);
    tick();
    chk("spur_idle_after", {54'd0, busy, bus.req_ready, bus.red_start, bus.rsp_valid}, 64'd0);
    rd[0] = 48'd3;
    rv    = 4'b0001;
    do_op(0, 48'd3, 23'd3, 1'b0, 1'b1, 5, 1'b1);
    tick();
    chk("spur_resp_after", {54'd0, busy, bus.req_ready, bus.red_start, bus.rsp_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
